// File: rtl/seq_branch_comp_if.sv
// seq_branch_comp_if: request/response handshake bundle for the sliced branch comparator.
// slave is the comparator side, master is the requester/consumer side.
interface seq_branch_comp_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       funct3;
   logic             out_valid;
   logic             out_ready;
   logic             taken;
   logic             eq;
   logic             lt;
   logic             illegal;

   modport slave (
      input  in_valid, a, b, funct3, out_ready,
      output in_ready, out_valid, taken, eq, lt, illegal
   );

   modport master (
      output in_valid, a, b, funct3, out_ready,
      input  in_ready, out_valid, taken, eq, lt, illegal
   );
endinterface

// File: rtl/seq_branch_comp.sv
// seq_branch_comp: multi-cycle RISC-V branch comparator, SLICE bits per cycle, MSB slice first.
// Optional CMP_EARLY_EXIT_EN leaves SCAN on the first differing slice; results are identical either way.
module seq_branch_comp #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input logic              clk,
   input logic              rst_n,
   seq_branch_comp_if.slave bus
);
   // state | meaning
   // IDLE  | ready for a request; operands latched on in_valid
   // SCAN  | one slice compared per cycle, idx counting down to 0
   // DONE  | result held on registered outputs until out_ready
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   generate
      if (WIDTH % SLICE != 0) begin : g_bad_slice
         $error("seq_branch_comp: WIDTH must be a multiple of SLICE");
      end
   endgenerate

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2:0]         funct3_q, funct3_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               decided_q, decided_d;
   logic               lt_raw_q, lt_raw_d;
   logic               out_valid_q, out_valid_d;
   logic               taken_q, taken_d;
   logic               eq_q, eq_d;
   logic               lt_q, lt_d;
   logic               illegal_q, illegal_d;

   logic [WIDTH-1:0]   a_shift, b_shift;
   logic [SLICE-1:0]   a_sl, b_sl;
   logic               slice_diff, dec_now, lt_now, last_slice;
   logic               fin_eq, fin_lt, fin_taken, fin_illegal, signed_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         funct3_q    <= '0;
         idx_q       <= '0;
         decided_q   <= 1'b0;
         lt_raw_q    <= 1'b0;
         out_valid_q <= 1'b0;
         taken_q     <= 1'b0;
         eq_q        <= 1'b0;
         lt_q        <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         funct3_q    <= funct3_d;
         idx_q       <= idx_d;
         decided_q   <= decided_d;
         lt_raw_q    <= lt_raw_d;
         out_valid_q <= out_valid_d;
         taken_q     <= taken_d;
         eq_q        <= eq_d;
         lt_q        <= lt_d;
         illegal_q   <= illegal_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      funct3_d    = funct3_q;
      idx_d       = idx_q;
      decided_d   = decided_q;
      lt_raw_d    = lt_raw_q;
      out_valid_d = out_valid_q;
      taken_d     = taken_q;
      eq_d        = eq_q;
      lt_d        = lt_q;
      illegal_d   = illegal_q;

      a_shift    = a_q >> (int'(idx_q) * SLICE);
      b_shift    = b_q >> (int'(idx_q) * SLICE);
      a_sl       = a_shift[SLICE-1:0];
      b_sl       = b_shift[SLICE-1:0];
      slice_diff = (a_sl != b_sl);
      dec_now    = decided_q | slice_diff;
      lt_now     = decided_q ? lt_raw_q : (a_sl < b_sl);

      fin_eq      = ~dec_now;
      fin_lt      = lt_now & dec_now;
      fin_taken   = 1'b0;
      fin_illegal = 1'b0;
      case (funct3_q)
         3'b000:         fin_taken = fin_eq;
         3'b001:         fin_taken = ~fin_eq;
         3'b100, 3'b110: fin_taken = fin_lt;
         3'b101, 3'b111: fin_taken = ~fin_lt;
         default:        fin_illegal = 1'b1;
      endcase

      last_slice = (idx_q == '0);
`ifdef CMP_EARLY_EXIT_EN
      last_slice = last_slice | slice_diff;
`endif

      // Flipping the operand sign bits turns a signed compare into an unsigned one.
      signed_mode = (bus.funct3[2:1] == 2'b10);

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d       = bus.a ^ {signed_mode, {(WIDTH-1){1'b0}}};
               b_d       = bus.b ^ {signed_mode, {(WIDTH-1){1'b0}}};
               funct3_d  = bus.funct3;
               idx_d     = IDX_W'(NSLICE - 1);
               decided_d = 1'b0;
               lt_raw_d  = 1'b0;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            decided_d = dec_now;
            lt_raw_d  = lt_now;
            idx_d     = idx_q - IDX_W'(1);
            if (last_slice) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               eq_d        = fin_eq;
               lt_d        = fin_lt;
               taken_d     = fin_taken;
               illegal_d   = fin_illegal;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               eq_d        = 1'b0;
               lt_d        = 1'b0;
               taken_d     = 1'b0;
               illegal_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.taken     = taken_q;
   assign bus.eq        = eq_q;
   assign bus.lt        = lt_q;
   assign bus.illegal   = illegal_q;
endmodule
